// File: rtl/al_accel_acc_matrix_pkg.sv
// rtl/al_accel_acc_matrix_pkg.sv - shared constants for the accumulation stage
// Purpose: data width, channel count and window geometry shared by the
//          accumulation top level and its adder tree.
package al_accel_acc_matrix_pkg;

  localparam int ACC_DATA_W  = 32;
  localparam int ACC_N_CH    = 3;
  localparam int ACC_WIN     = 3;
  localparam int ACC_N_TERMS = ACC_WIN * ACC_WIN;

endpackage

// File: rtl/al_accel_acc_sum9.sv
// rtl/al_accel_acc_sum9.sv - combinational 9-input adder tree
// Purpose: sums the nine window products of one output channel, modulo 2^DATA_W.
// Ports:
//   i_terms  in   9 x DATA_W  window products, any order
//   o_sum    out  DATA_W      truncated sum of all nine terms
module al_accel_acc_sum9
  import al_accel_acc_matrix_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W
) (
  input  logic [ACC_N_TERMS-1:0][DATA_W-1:0] i_terms,
  output logic [DATA_W-1:0]                  o_sum
);

  // Balanced tree: 9 -> 5 -> 3 -> 2 -> 1. The odd term at each level is
  // carried forward unchanged so depth stays at four adders.
  logic [DATA_W-1:0] w_l1 [5];
  logic [DATA_W-1:0] w_l2 [3];
  logic [DATA_W-1:0] w_l3 [2];

  for (genvar g = 0; g < 4; g++) begin : g_l1
    assign w_l1[g] = i_terms[2*g] + i_terms[2*g+1];
  end
  assign w_l1[4] = i_terms[8];

  assign w_l2[0] = w_l1[0] + w_l1[1];
  assign w_l2[1] = w_l1[2] + w_l1[3];
  assign w_l2[2] = w_l1[4];

  assign w_l3[0] = w_l2[0] + w_l2[1];
  assign w_l3[1] = w_l2[2];

  assign o_sum = w_l3[0] + w_l3[1];

endmodule

// File: rtl/al_accel_acc_matrix.sv
// rtl/al_accel_acc_matrix.sv - per-channel bias load, window accumulate, publish
// Purpose: for each of three output channels, holds a bias/partial sum, adds a
//          3x3 window of products to it, and exposes the result as a register.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   enb                          global enable; low freezes every register
//   acc_matrix_bps_load          capture acc_matrix_bps_n into the bias register
//   acc_matrix_bps_write         acc <= bias + sum of the channel's nine di inputs
//   acc_matrix_inter_sum_write   do <= acc
//   acc_matrix_bps_0..2          bias/partial sum per channel
//   acc_matrix_di_<r>_<c>_<n>    window products, row r, col c, channel n
//   acc_matrix_do_0..2           registered result per channel
module al_accel_acc_matrix
  import al_accel_acc_matrix_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int N_CH   = ACC_N_CH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enb,
  input  logic              acc_matrix_bps_load,
  input  logic              acc_matrix_bps_write,
  input  logic              acc_matrix_inter_sum_write,
  input  logic [DATA_W-1:0] acc_matrix_bps_0,
  input  logic [DATA_W-1:0] acc_matrix_bps_1,
  input  logic [DATA_W-1:0] acc_matrix_bps_2,
  input  logic [DATA_W-1:0] acc_matrix_di_0_0_0,
  input  logic [DATA_W-1:0] acc_matrix_di_0_1_0,
  input  logic [DATA_W-1:0] acc_matrix_di_0_2_0,
  input  logic [DATA_W-1:0] acc_matrix_di_1_0_0,
  input  logic [DATA_W-1:0] acc_matrix_di_1_1_0,
  input  logic [DATA_W-1:0] acc_matrix_di_1_2_0,
  input  logic [DATA_W-1:0] acc_matrix_di_2_0_0,
  input  logic [DATA_W-1:0] acc_matrix_di_2_1_0,
  input  logic [DATA_W-1:0] acc_matrix_di_2_2_0,
  input  logic [DATA_W-1:0] acc_matrix_di_0_0_1,
  input  logic [DATA_W-1:0] acc_matrix_di_0_1_1,
  input  logic [DATA_W-1:0] acc_matrix_di_0_2_1,
  input  logic [DATA_W-1:0] acc_matrix_di_1_0_1,
  input  logic [DATA_W-1:0] acc_matrix_di_1_1_1,
  input  logic [DATA_W-1:0] acc_matrix_di_1_2_1,
  input  logic [DATA_W-1:0] acc_matrix_di_2_0_1,
  input  logic [DATA_W-1:0] acc_matrix_di_2_1_1,
  input  logic [DATA_W-1:0] acc_matrix_di_2_2_1,
  input  logic [DATA_W-1:0] acc_matrix_di_0_0_2,
  input  logic [DATA_W-1:0] acc_matrix_di_0_1_2,
  input  logic [DATA_W-1:0] acc_matrix_di_0_2_2,
  input  logic [DATA_W-1:0] acc_matrix_di_1_0_2,
  input  logic [DATA_W-1:0] acc_matrix_di_1_1_2,
  input  logic [DATA_W-1:0] acc_matrix_di_1_2_2,
  input  logic [DATA_W-1:0] acc_matrix_di_2_0_2,
  input  logic [DATA_W-1:0] acc_matrix_di_2_1_2,
  input  logic [DATA_W-1:0] acc_matrix_di_2_2_2,
  output logic [DATA_W-1:0] acc_matrix_do_0,
  output logic [DATA_W-1:0] acc_matrix_do_1,
  output logic [DATA_W-1:0] acc_matrix_do_2
);

  logic [ACC_N_TERMS-1:0][DATA_W-1:0] w_terms [N_CH];
  logic [DATA_W-1:0]                  w_bps   [N_CH];
  logic [DATA_W-1:0]                  w_sum   [N_CH];

  logic [DATA_W-1:0] r_bps [N_CH];
  logic [DATA_W-1:0] r_acc [N_CH];
  logic [DATA_W-1:0] r_do  [N_CH];

  assign w_terms[0] = {acc_matrix_di_2_2_0, acc_matrix_di_2_1_0, acc_matrix_di_2_0_0,
                       acc_matrix_di_1_2_0, acc_matrix_di_1_1_0, acc_matrix_di_1_0_0,
                       acc_matrix_di_0_2_0, acc_matrix_di_0_1_0, acc_matrix_di_0_0_0};
  assign w_terms[1] = {acc_matrix_di_2_2_1, acc_matrix_di_2_1_1, acc_matrix_di_2_0_1,
                       acc_matrix_di_1_2_1, acc_matrix_di_1_1_1, acc_matrix_di_1_0_1,
                       acc_matrix_di_0_2_1, acc_matrix_di_0_1_1, acc_matrix_di_0_0_1};
  assign w_terms[2] = {acc_matrix_di_2_2_2, acc_matrix_di_2_1_2, acc_matrix_di_2_0_2,
                       acc_matrix_di_1_2_2, acc_matrix_di_1_1_2, acc_matrix_di_1_0_2,
                       acc_matrix_di_0_2_2, acc_matrix_di_0_1_2, acc_matrix_di_0_0_2};

  assign w_bps[0] = acc_matrix_bps_0;
  assign w_bps[1] = acc_matrix_bps_1;
  assign w_bps[2] = acc_matrix_bps_2;

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    al_accel_acc_sum9 #(
      .DATA_W (DATA_W)
    ) u_sum9 (
      .i_terms (w_terms[n]),
      .o_sum   (w_sum[n])
    );
  end

  // The three strobes are decoded independently; every right-hand side reads
  // the pre-edge register value, so load+write in one cycle accumulates the
  // old bias and write+publish in one cycle publishes the old accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < N_CH; n++) begin
        r_bps[n] <= '0;
        r_acc[n] <= '0;
        r_do[n]  <= '0;
      end
    end else if (enb) begin
      for (int n = 0; n < N_CH; n++) begin
        if (acc_matrix_bps_load)        r_bps[n] <= w_bps[n];
        if (acc_matrix_bps_write)       r_acc[n] <= r_bps[n] + w_sum[n];
        if (acc_matrix_inter_sum_write) r_do[n]  <= r_acc[n];
      end
    end
  end

  assign acc_matrix_do_0 = r_do[0];
  assign acc_matrix_do_1 = r_do[1];
  assign acc_matrix_do_2 = r_do[2];

endmodule

// File: tb/tb_al_accel_acc_matrix.sv
// tb/tb_al_accel_acc_matrix.sv - self-checking bench for al_accel_acc_matrix
module tb_al_accel_acc_matrix;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enb;
  logic        ld, wr, it;
  logic [31:0] bps [3];
  logic [31:0] di  [3][3][3];   // [row][col][channel]
  logic [31:0] dout [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  al_accel_acc_matrix dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .enb                        (enb),
    .acc_matrix_bps_load        (ld),
    .acc_matrix_bps_write       (wr),
    .acc_matrix_inter_sum_write (it),
    .acc_matrix_bps_0           (bps[0]),
    .acc_matrix_bps_1           (bps[1]),
    .acc_matrix_bps_2           (bps[2]),
    .acc_matrix_di_0_0_0        (di[0][0][0]),
    .acc_matrix_di_0_1_0        (di[0][1][0]),
    .acc_matrix_di_0_2_0        (di[0][2][0]),
    .acc_matrix_di_1_0_0        (di[1][0][0]),
    .acc_matrix_di_1_1_0        (di[1][1][0]),
    .acc_matrix_di_1_2_0        (di[1][2][0]),
    .acc_matrix_di_2_0_0        (di[2][0][0]),
    .acc_matrix_di_2_1_0        (di[2][1][0]),
    .acc_matrix_di_2_2_0        (di[2][2][0]),
    .acc_matrix_di_0_0_1        (di[0][0][1]),
    .acc_matrix_di_0_1_1        (di[0][1][1]),
    .acc_matrix_di_0_2_1        (di[0][2][1]),
    .acc_matrix_di_1_0_1        (di[1][0][1]),
    .acc_matrix_di_1_1_1        (di[1][1][1]),
    .acc_matrix_di_1_2_1        (di[1][2][1]),
    .acc_matrix_di_2_0_1        (di[2][0][1]),
    .acc_matrix_di_2_1_1        (di[2][1][1]),
    .acc_matrix_di_2_2_1        (di[2][2][1]),
    .acc_matrix_di_0_0_2        (di[0][0][2]),
    .acc_matrix_di_0_1_2        (di[0][1][2]),
    .acc_matrix_di_0_2_2        (di[0][2][2]),
    .acc_matrix_di_1_0_2        (di[1][0][2]),
    .acc_matrix_di_1_1_2        (di[1][1][2]),
    .acc_matrix_di_1_2_2        (di[1][2][2]),
    .acc_matrix_di_2_0_2        (di[2][0][2]),
    .acc_matrix_di_2_1_2        (di[2][1][2]),
    .acc_matrix_di_2_2_2        (di[2][2][2]),
    .acc_matrix_do_0            (dout[0]),
    .acc_matrix_do_1            (dout[1]),
    .acc_matrix_do_2            (dout[2])
  );

  // One cycle of stimulus and the outputs required after its edge. Channel n's
  // nine di all take f[n], except di_0_0_0 which takes d000.
  typedef struct {
    logic        enb, ld, wr, it;
    logic [31:0] b0, b1, b2;
    logic [31:0] f0, f1, f2, d000;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic en, logic l, logic w, logic i,
                              logic [31:0] b0, logic [31:0] b1, logic [31:0] b2,
                              logic [31:0] f0, logic [31:0] f1, logic [31:0] f2,
                              logic [31:0] d000,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v.enb = en; v.ld = l; v.wr = w; v.it = i;
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.f0 = f0; v.f1 = f1; v.f2 = f2; v.d000 = d000;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_do(input string name, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2);
    check({name, ".do_0"}, dout[0], e0);
    check({name, ".do_1"}, dout[1], e1);
    check({name, ".do_2"}, dout[2], e2);
  endtask

  task automatic set_di(input logic [31:0] f0, input logic [31:0] f1,
                        input logic [31:0] f2, input logic [31:0] d000);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        di[r][c][0] = f0;
        di[r][c][1] = f1;
        di[r][c][2] = f2;
      end
    di[0][0][0] = d000;
  endtask

  task automatic randomize_inputs();
    for (int n = 0; n < 3; n++) begin
      bps[n] = $urandom;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) di[r][c][n] = $urandom;
    end
  endtask

  logic [31:0] m_bps [3];
  logic [31:0] m_acc [3];
  logic [31:0] m_do  [3];
  logic [31:0] s;

  initial begin
    // Directed vectors; expected values worked by hand.
    tbl[0]  = mk(1,1,0,0, 10,100,0,            1,2,0,1,  0,0,0);
    tbl[1]  = mk(1,0,1,0, 0,0,0,               1,2,0,1,  0,0,0);
    tbl[2]  = mk(1,0,0,1, 0,0,0,               0,0,0,0,  19,118,0);
    tbl[3]  = mk(0,1,0,0, 50,60,70,            5,5,5,5,  19,118,0);
    tbl[4]  = mk(0,0,1,0, 50,60,70,            5,5,5,5,  19,118,0);
    tbl[5]  = mk(0,0,0,1, 50,60,70,            5,5,5,5,  19,118,0);
    tbl[6]  = mk(1,1,0,0, 32'hFFFF_FFFF,0,0,   0,0,0,1,  19,118,0);
    tbl[7]  = mk(1,0,1,0, 0,0,0,               0,0,0,1,  19,118,0);
    tbl[8]  = mk(1,0,0,1, 0,0,0,               0,0,0,0,  0,0,0);
    tbl[9]  = mk(1,1,0,0, 5,3,4,               0,0,0,0,  0,0,0);
    tbl[10] = mk(1,0,1,0, 0,0,0,               0,0,0,0,  0,0,0);
    tbl[11] = mk(1,0,0,1, 0,0,0,               0,0,0,0,  5,3,4);
    tbl[12] = mk(1,1,1,0, 7,8,9,               1,1,1,1,  5,3,4);
    tbl[13] = mk(1,0,0,1, 0,0,0,               0,0,0,0,  14,12,13);
    tbl[14] = mk(1,0,1,0, 0,0,0,               0,0,0,0,  14,12,13);
    tbl[15] = mk(1,0,0,1, 0,0,0,               0,0,0,0,  7,8,9);
    tbl[16] = mk(1,0,1,0, 0,0,0,               1,1,1,1,  7,8,9);
    tbl[17] = mk(1,0,1,0, 0,0,0,               1,1,1,1,  7,8,9);
    tbl[18] = mk(1,0,0,1, 0,0,0,               0,0,0,0,  16,17,18);
    tbl[19] = mk(1,1,1,1, 100,200,300,         2,2,2,2,  16,17,18);
    tbl[20] = mk(1,0,0,1, 0,0,0,               0,0,0,0,  25,26,27);
    tbl[21] = mk(1,0,0,0, 0,0,0,               9,9,9,9,  25,26,27);

    // Reset held with random inputs and live strobes.
    resetn = 1'b0;
    enb = 1'b1; ld = 1'b1; wr = 1'b1; it = 1'b1;
    randomize_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_do("reset_hold", 0, 0, 0);
    ld = 1'b0; wr = 1'b0; it = 1'b0;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_do("reset_release_idle", 0, 0, 0);

    for (int k = 0; k < 22; k++) begin
      enb = tbl[k].enb; ld = tbl[k].ld; wr = tbl[k].wr; it = tbl[k].it;
      bps[0] = tbl[k].b0; bps[1] = tbl[k].b1; bps[2] = tbl[k].b2;
      set_di(tbl[k].f0, tbl[k].f1, tbl[k].f2, tbl[k].d000);
      @(posedge clk);
      #1;
      check_do($sformatf("vec%0d", k), tbl[k].e0, tbl[k].e1, tbl[k].e2);
    end

    // Reset between write and publish discards the sum; reset acts without a clock.
    ld = 1'b1; wr = 1'b0; it = 1'b0;
    bps[0] = 1; bps[1] = 2; bps[2] = 3;
    @(posedge clk); #1;
    ld = 1'b0; wr = 1'b1;
    set_di(1, 1, 1, 1);
    @(posedge clk); #1;
    wr = 1'b0;
    check_do("pre_reset_hold", 25, 26, 27);
    #2 resetn = 1'b0;
    #1;
    check_do("async_reset", 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    it = 1'b1;
    @(posedge clk); #1;
    it = 1'b0;
    check_do("publish_after_reset", 0, 0, 0);

    // Random sequence against a reference model.
    for (int n = 0; n < 3; n++) begin
      m_bps[n] = '0; m_acc[n] = '0; m_do[n] = '0;
    end
    for (int k = 0; k < 40; k++) begin
      enb = ($urandom_range(0, 5) != 0);
      ld  = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1);
      it  = $urandom_range(0, 1);
      randomize_inputs();
      if (enb) begin
        for (int n = 0; n < 3; n++) begin
          if (it) m_do[n] = m_acc[n];
          if (wr) begin
            s = m_bps[n];
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++) s = s + di[r][c][n];
            m_acc[n] = s;
          end
          if (ld) m_bps[n] = bps[n];
        end
      end
      @(posedge clk);
      #1;
      check_do($sformatf("rand%0d", k), m_do[0], m_do[1], m_do[2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
